bus_bridge_slave: RTL and testbench
===================================

BUS_BRIDGE_SLAVE -- requirements
Module: bus_bridge_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the bus data word.
REQ-002 Parameter ADDR_WIDTH, default 13: width of the slave-local address.
REQ-003 Parameter UART_CLOCKS_PER_PULSE, default 5208: number of clk cycles per UART bit.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port swdata, input, 1 bit: serial write address/data from the bus, LSB first.
REQ-007 Port smode, input, 1 bit: 0 = read, 1 = write; sampled with the first address bit.
REQ-008 Port mvalid, input, 1 bit: swdata/smode valid this cycle.
REQ-009 Port srdata, output, 1 bit: serial read data to the bus, LSB first.
REQ-010 Port svalid, output, 1 bit: srdata valid this cycle.
REQ-011 Port sready, output, 1 bit: slave idle and able to accept a transaction.
REQ-012 Port split_grant, input, 1 bit: split resume grant; ignored by this block.
REQ-013 Port ssplit, output, 1 bit: split request; SHALL be held at 0 because this block does not split.
REQ-014 Port u_tx, output, 1 bit: UART transmit line; idle level is 1.
REQ-015 Port u_rx, input, 1 bit: UART receive line; idle level is 1.
REQ-016 An internal signal u_tx_busy SHALL be high from UART transmit start to the end of the stop bit; verification probes it hierarchically.

Function
REQ-017 States SHALL be IDLE, ADDR, WDATA, UART_TX, WAIT_RX and RDATA.
REQ-018 IDLE: sready=1; on mvalid=1, capture the first address bit and smode, drop sready, go to ADDR.
- If ADDR_WIDTH == 1, go straight to WDATA (write) or UART_TX (read).
REQ-019 ADDR: shift one address bit per cycle while mvalid=1 (bit i at position i).
- Cycles with mvalid=0 SHALL hold state.
- After ADDR_WIDTH bits, go to WDATA (write) or UART_TX (read).
REQ-020 WDATA: shift DATA_WIDTH bits LSB first while mvalid=1, then go to UART_TX.
REQ-021 UART_TX: load the frame {data, addr, mode} (DATA_WIDTH+ADDR_WIDTH+1 bits, mode at bit 0) into the UART transmitter.
- For a read, the data field SHALL be zero.
- A write SHALL then return to IDLE with sready=1 on the next cycle, while u_tx_busy may still be 1.
- A read SHALL go to WAIT_RX.
REQ-022 UART transmit format: start bit 0, then frame bits LSB first, then stop bit 1, each held UART_CLOCKS_PER_PULSE cycles.
- Total frame length = (DATA_WIDTH+ADDR_WIDTH+3) × UART_CLOCKS_PER_PULSE cycles.
REQ-023 A new frame arriving while u_tx_busy=1 SHALL stall in UART_TX until u_tx_busy=0.
- No frame SHALL ever be dropped or overlapped.
REQ-024 UART receive: detect the falling start edge and re-check it at mid-bit.
- Sample each of DATA_WIDTH bits at mid-bit, LSB first, then check the stop bit.
- Raise an internal rx_done pulse for 1 cycle.
- A bad stop bit SHALL discard the word.
REQ-025 WAIT_RX: on rx_done, latch the received word and go to RDATA; there is no timeout.
- rx_done outside WAIT_RX SHALL be ignored.
REQ-026 RDATA: drive svalid=1 and srdata=bit k on the k-th cycle for DATA_WIDTH consecutive cycles.
- Then drop svalid, set sready=1, go to IDLE.
REQ-027 mvalid in WAIT_RX, RDATA or UART_TX SHALL be ignored.

Reset
REQ-028 While rstn=0 (immediately, asynchronously):
- state=IDLE, sready=1, svalid=0, srdata=0, ssplit=0.
- u_tx=1, u_tx_busy=0, all shift registers and counters cleared.
REQ-029 Reset during any state, including mid-UART frame, SHALL abort the transaction with no partial frame resumed after release.

Structure
REQ-030 Frame width, UART state encodings and slave state encodings SHALL live in a shared bus package.
REQ-031 UART transmit and receive SHALL be one sub-module, uart, parameterised by TX width, RX width and UART_CLOCKS_PER_PULSE.

Verification
REQ-032 Write, with UART_CLOCKS_PER_PULSE=16: addr 0x0123, data 0xA5 -> u_tx carries frame 0x294247, frame lasts 24×16 cycles, sready returns to 1.
REQ-033 Read addr 0x0ABC -> frame 0x001578 on u_tx; then drive byte 0x3C on u_rx -> svalid high 8 cycles with srdata 0,0,1,1,1,1,0,0 -> sready=1.
REQ-034 Back-to-back writes issued while u_tx_busy=1 -> second frame starts only after the first stop bit, both frames bit-exact.
REQ-035 rstn low mid-frame -> u_tx=1 and sready=1 immediately; a following write completes correctly.
REQ-036 A glitched start bit on u_rx (low for under half a bit) -> no rx_done; state stays WAIT_RX.
REQ-037 After any transaction, ssplit SHALL remain 0 throughout, independent of split_grant.

Source files
------------

// File: rtl/bus_bridge_slave_pkg.sv
// rtl/bus_bridge_slave_pkg.sv - shared frame width helper and bus/UART state encodings
package bus_bridge_slave_pkg;

  // Slave-side transaction sequencing
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    UART_TX,
    WAIT_RX,
    RDATA
  } slave_state_e;

  // UART transmitter phases
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_e;

  // UART receiver phases
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_e;

  // Outgoing UART frame is {data, addr, mode}
  function automatic int frame_width(input int data_width, input int addr_width);
    return data_width + addr_width + 1;
  endfunction

endpackage

// File: rtl/uart.sv
// rtl/uart.sv - UART transmitter and receiver sharing one bit period
module uart
  import bus_bridge_slave_pkg::*;
#(
  parameter int TX_WIDTH       = 22,
  parameter int RX_WIDTH       = 8,
  parameter int CLKS_PER_PULSE = 5208
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tx_start,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic                tx_busy,
  output logic                tx,
  input  logic                rx,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_done
);

  localparam int CW  = $clog2(CLKS_PER_PULSE + 1);
  localparam int TIW = $clog2(TX_WIDTH + 1);
  localparam int RIW = $clog2(RX_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_PULSE - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_PULSE / 2 - 1);
  localparam logic [TIW-1:0] TX_LAST  = TIW'(TX_WIDTH - 1);
  localparam logic [RIW-1:0] RX_LAST  = RIW'(RX_WIDTH - 1);

  uart_tx_state_e    tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [TIW-1:0]    tx_idx_q, tx_idx_d;
  logic [TX_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;

  uart_rx_state_e    rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [RIW-1:0]    rx_idx_q, rx_idx_d;
  logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

  // Transmit: start bit, frame LSB first, stop bit, each a full bit period
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      default: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          case (tx_state_q)
            TX_START: begin
              tx_d       = tx_shift_q[0];
              tx_shift_d = tx_shift_q >> 1;
              tx_idx_d   = '0;
              tx_state_d = TX_DATA;
            end
            TX_DATA: begin
              if (tx_idx_q == TX_LAST) begin
                tx_d       = 1'b1;
                tx_state_d = TX_STOP;
              end else begin
                tx_d       = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
                tx_idx_d   = tx_idx_q + TIW'(1);
              end
            end
            default: tx_state_d = TX_IDLE;
          endcase
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Receive: falling edge, mid-bit start re-check, mid-bit data samples, stop check
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = (rx_shift_q >> 1) | (RX_WIDTH'(rx_sync_q) << (RX_WIDTH - 1));
          if (rx_idx_q == RX_LAST) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + RIW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State registers; the rx line is double-synchronised before edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

endmodule

// File: rtl/bus_bridge_slave.sv
// rtl/bus_bridge_slave.sv - serial bus slave bridging transactions onto a UART link
module bus_bridge_slave
  import bus_bridge_slave_pkg::*;
#(
  parameter int DATA_WIDTH            = 8,
  parameter int ADDR_WIDTH            = 13,
  parameter int UART_CLOCKS_PER_PULSE = 5208
) (
  input  logic clk,
  input  logic rstn,
  input  logic swdata,
  input  logic smode,
  input  logic mvalid,
  output logic srdata,
  output logic svalid,
  output logic sready,
  input  logic split_grant,
  output logic ssplit,
  output logic u_tx,
  input  logic u_rx
);

  localparam int FW      = frame_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int CNT_MAX = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  slave_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sready_q, sready_d;
  logic                  svalid_q, svalid_d;
  logic                  srdata_q, srdata_d;

  logic                  tx_start;
  logic                  u_tx_busy;
  logic [FW-1:0]         tx_frame;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  rx_done;
  logic                  unused_split_grant;

  // This slave never splits, so the resume grant has no effect
  assign unused_split_grant = split_grant;
  assign ssplit = 1'b0;
  assign sready = sready_q;
  assign svalid = svalid_q;
  assign srdata = srdata_q;

  // Reads carry an all-zero data field
  assign tx_frame = {(mode_q ? data_q : {DATA_WIDTH{1'b0}}), addr_q, mode_q};
  assign tx_start = (state_q == UART_TX) && !u_tx_busy;

  // Transaction sequencing; address and data shift in from the top so bit i lands at i
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    sready_d = sready_q;
    svalid_d = svalid_q;
    srdata_d = srdata_q;
    case (state_q)
      IDLE: begin
        if (mvalid) begin
          addr_d   = (addr_q >> 1) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - 1));
          mode_d   = smode;
          sready_d = 1'b0;
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = smode ? WDATA : UART_TX;
          end else begin
            cnt_d   = CW'(1);
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (mvalid) begin
          addr_d = (addr_q >> 1) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - 1));
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = mode_q ? WDATA : UART_TX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          data_d = (data_q >> 1) | (DATA_WIDTH'(swdata) << (DATA_WIDTH - 1));
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = UART_TX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      UART_TX: begin
        if (!u_tx_busy) begin
          if (mode_q) begin
            sready_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_RX;
          end
        end
      end
      WAIT_RX: begin
        if (rx_done) begin
          srdata_d = rx_word[0];
          rdata_d  = rx_word >> 1;
          svalid_d = 1'b1;
          cnt_d    = CW'(1);
          state_d  = RDATA;
        end
      end
      default: begin
        if (cnt_q == CW'(DATA_WIDTH)) begin
          svalid_d = 1'b0;
          srdata_d = 1'b0;
          sready_d = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          srdata_d = rdata_q[0];
          rdata_d  = rdata_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Slave registers including the registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      sready_q <= 1'b1;
      svalid_q <= 1'b0;
      srdata_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      sready_q <= sready_d;
      svalid_q <= svalid_d;
      srdata_q <= srdata_d;
    end
  end

  uart #(
    .TX_WIDTH      (FW),
    .RX_WIDTH      (DATA_WIDTH),
    .CLKS_PER_PULSE(UART_CLOCKS_PER_PULSE)
  ) u_uart (
    .clk     (clk),
    .rstn    (rstn),
    .tx_start(tx_start),
    .tx_data (tx_frame),
    .tx_busy (u_tx_busy),
    .tx      (u_tx),
    .rx      (u_rx),
    .rx_data (rx_word),
    .rx_done (rx_done)
  );

endmodule

// File: tb/tb_bus_bridge_slave.sv
// tb/tb_bus_bridge_slave.sv - self-checking bench for bus_bridge_slave
module tb_bus_bridge_slave;

  localparam int DW   = 8;
  localparam int AW   = 13;
  localparam int CPP  = 16;
  localparam int FW   = DW + AW + 1;
  localparam int FLEN = (DW + AW + 3) * CPP;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic swdata = 1'b0;
  logic smode = 1'b0;
  logic mvalid = 1'b0;
  logic split_grant = 1'b0;
  logic u_rx = 1'b1;
  logic srdata, svalid, sready, ssplit, u_tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_count = 0;
  bit ssplit_seen = 1'b0;

  logic [FW-1:0] mon_frame[$];
  bit            mon_stop[$];
  int            mon_start[$];
  int            mon_dur[$];
  logic [FW-1:0] exp_frame[$];
  bit            rd_bits[$];
  int            rd_cyc[$];

  bus_bridge_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .UART_CLOCKS_PER_PULSE(CPP)
  ) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .split_grant(split_grant),
    .ssplit(ssplit), .u_tx(u_tx), .u_rx(u_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rstn) rst_count = rst_count + 1;

  always @(negedge clk) begin
    if (ssplit !== 1'b0) ssplit_seen = 1'b1;
    if (svalid === 1'b1) begin
      rd_bits.push_back(srdata);
      rd_cyc.push_back(cyc);
    end
  end

  initial begin : grant_noise
    forever begin
      @(negedge clk);
      split_grant = 1'($urandom_range(0, 1));
    end
  end

  // Captures every complete UART frame on u_tx; frames cut by reset are dropped
  initial begin : uart_mon
    logic [FW-1:0] f;
    int st, rc;
    bit ok;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && u_tx === 1'b0) begin
        st = cyc;
        rc = rst_count;
        f  = '0;
        repeat (CPP / 2) @(negedge clk);
        ok = (u_tx === 1'b0);
        for (int i = 0; i < FW; i++) begin
          repeat (CPP) @(negedge clk);
          f[i] = u_tx;
        end
        repeat (CPP) @(negedge clk);
        ok = ok && (u_tx === 1'b1);
        while (dut.u_tx_busy === 1'b1 && (cyc - st) < 4 * FLEN) @(negedge clk);
        if (rc == rst_count) begin
          mon_frame.push_back(f);
          mon_stop.push_back(ok);
          mon_start.push_back(st);
          mon_dur.push_back(cyc - st);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: time limit reached with errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [FW-1:0] model_frame(input bit mode, input logic [AW-1:0] a,
                                                input logic [DW-1:0] d);
    longint unsigned v;
    v = (mode ? 64'(d) : 64'd0) * (64'd1 << (AW + 1)) + 64'(a) * 64'd2 + 64'(mode);
    return FW'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sready(input string tag);
    int n = 0;
    while (sready !== 1'b1 && n < 4 * FLEN) begin
      @(negedge clk);
      n++;
    end
    check({tag, " sready"}, 64'(sready), 64'd1);
  endtask

  task automatic send_txn(input bit mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int nbits;
    wait_sready("pre-txn");
    exp_frame.push_back(model_frame(mode, a, d));
    nbits = AW + (mode ? DW : 0);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mvalid = 1'b0;
        swdata = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      mvalid = 1'b1;
      smode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
      swdata = (i < AW) ? a[i] : d[i - AW];
    end
    @(negedge clk);
    mvalid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget = 0;
    while (mon_frame.size() < n && budget < (n + 2) * 2 * FLEN) begin
      @(negedge clk);
      budget++;
    end
    check({tag, " frame count"}, 64'(mon_frame.size()), 64'(n));
  endtask

  task automatic check_frames(input int n, input string tag);
    int prev_start = 0;
    wait_frames(n, tag);
    for (int k = 0; k < n && mon_frame.size() > 0 && exp_frame.size() > 0; k++) begin
      check({tag, " frame"}, 64'(mon_frame.pop_front()), 64'(exp_frame.pop_front()));
      check({tag, " stop bit"}, 64'(mon_stop.pop_front()), 64'd1);
      check({tag, " frame length"}, 64'(mon_dur.pop_front()), 64'(FLEN));
      if (k > 0) check({tag, " no overlap"}, 64'((mon_start[0] - prev_start) >= FLEN), 64'd1);
      prev_start = mon_start.pop_front();
    end
  endtask

  task automatic drive_rx(input logic [DW-1:0] b, input bit stop);
    @(negedge clk) u_rx = 1'b0;
    repeat (CPP - 1) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      @(negedge clk) u_rx = b[i];
      repeat (CPP - 1) @(negedge clk);
    end
    @(negedge clk) u_rx = stop;
    repeat (CPP - 1) @(negedge clk);
    @(negedge clk) u_rx = 1'b1;
    repeat (2 * CPP) @(negedge clk);
  endtask

  task automatic check_read(input logic [DW-1:0] b, input string tag);
    logic [DW-1:0] v = '0;
    check({tag, " svalid cycles"}, 64'(rd_bits.size()), 64'(DW));
    if (rd_bits.size() == DW) begin
      for (int k = 0; k < DW; k++) v[k] = rd_bits[k];
      check({tag, " read word"}, 64'(v), 64'(b));
      check({tag, " consecutive"}, 64'(rd_cyc[DW-1] - rd_cyc[0]), 64'(DW - 1));
    end
    check({tag, " sready after"}, 64'(sready), 64'd1);
    check({tag, " svalid after"}, 64'(svalid), 64'd0);
    rd_bits.delete();
    rd_cyc.delete();
  endtask

  initial begin : stimulus
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset sready", 64'(sready), 64'd1);
    check("reset svalid", 64'(svalid), 64'd0);
    check("reset srdata", 64'(srdata), 64'd0);
    check("reset ssplit", 64'(ssplit), 64'd0);
    check("reset u_tx", 64'(u_tx), 64'd1);
    check("reset busy", 64'(dut.u_tx_busy), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // A received word while idle is ignored
    drive_rx(8'h55, 1'b1);
    check("idle rx no svalid", 64'(rd_bits.size()), 64'd0);
    check("idle rx sready", 64'(sready), 64'd1);

    // Directed write
    send_txn(1'b1, 13'h0123, 8'hA5);
    wait_sready("write");
    check("write sready while busy", 64'(dut.u_tx_busy), 64'd1);
    wait_frames(1, "write");
    if (mon_frame.size() > 0) check("write literal frame", 64'(mon_frame[0]), 64'h294247);
    check_frames(1, "write");

    // Directed read
    send_txn(1'b0, 13'h0ABC, 8'h00);
    wait_frames(1, "read");
    if (mon_frame.size() > 0) check("read literal frame", 64'(mon_frame[0]), 64'h001578);
    check_frames(1, "read");
    check("read waits", 64'(sready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mvalid = 1'($urandom_range(0, 1));
      smode  = 1'($urandom_range(0, 1));
      swdata = 1'($urandom_range(0, 1));
    end
    @(negedge clk) mvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("mvalid ignored in WAIT_RX", 64'(sready), 64'd0);
    drive_rx(8'h3C, 1'b1);
    check_read(8'h3C, "read 0x3C");

    // Glitched start and bad stop bit are both discarded
    a = AW'($urandom);
    send_txn(1'b0, a, 8'h00);
    check_frames(1, "glitch read");
    @(negedge clk) u_rx = 1'b0;
    repeat (CPP / 4 - 1) @(negedge clk);
    @(negedge clk) u_rx = 1'b1;
    repeat (3 * CPP) @(negedge clk);
    check("glitch no svalid", 64'(rd_bits.size()), 64'd0);
    check("glitch stays WAIT_RX", 64'(sready), 64'd0);
    drive_rx(8'($urandom), 1'b0);
    check("bad stop no svalid", 64'(rd_bits.size()), 64'd0);
    check("bad stop stays WAIT_RX", 64'(sready), 64'd0);
    d = 8'($urandom);
    drive_rx(d, 1'b1);
    check_read(d, "random read");

    // Back-to-back random writes stall behind the busy transmitter
    for (int k = 0; k < 3; k++) send_txn(1'b1, AW'($urandom), DW'($urandom));
    check_frames(3, "back-to-back");

    // Reset in the middle of a frame
    send_txn(1'b1, AW'($urandom), DW'($urandom));
    for (int n = 0; n < 4 * FLEN && dut.u_tx_busy !== 1'b1; n++) @(negedge clk);
    repeat (100) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid-frame reset u_tx", 64'(u_tx), 64'd1);
    check("mid-frame reset sready", 64'(sready), 64'd1);
    check("mid-frame reset busy", 64'(dut.u_tx_busy), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_frame.delete();
    repeat (FLEN + 50) @(negedge clk);
    check("no resumed frame", 64'(mon_frame.size()), 64'd0);
    check("line idle after reset", 64'(u_tx), 64'd1);
    mon_frame.delete();
    mon_stop.delete();
    mon_start.delete();
    mon_dur.delete();
    send_txn(1'b1, AW'($urandom), DW'($urandom));
    check_frames(1, "post-reset write");

    check("ssplit never high", 64'(ssplit_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
